// File: rtl/soc_msp430_dac_spi_if.sv
// -----------------------------------------------------------------------------
// soc_msp430_dac_spi_if
// Producer-side word handshake for the DAC SPI master.
//   dac_val_i : 12-bit sample value
//   dac_cfg_i : 4-bit control nibble (frame bits [15:12])
//   dac_vld_i : producer word valid
//   dac_rdy_o : block can accept a word
// master = producer (MSP430 register / DMA side), slave = soc_msp430_dac_spi.
// -----------------------------------------------------------------------------
interface soc_msp430_dac_spi_if;
   logic [11:0] dac_val_i;
   logic [3:0]  dac_cfg_i;
   logic        dac_vld_i;
   logic        dac_rdy_o;

   modport master (output dac_val_i, output dac_cfg_i, output dac_vld_i,
                   input  dac_rdy_o);
   modport slave  (input  dac_val_i, input  dac_cfg_i, input  dac_vld_i,
                   output dac_rdy_o);
endinterface

// File: rtl/soc_msp430_dac_spi.sv
// -----------------------------------------------------------------------------
// soc_msp430_dac_spi
// SPI master serialising {cfg,val} 16-bit frames onto the 3-wire DAC link.
// One pending word slot lets frames run back-to-back.
//   mclk        : system clock
//   puc_rst     : asynchronous active-high reset
//   prod        : producer handshake (val/cfg/vld in, rdy out)
//   clk_div_i   : sclk half-period = clk_div_i+1 mclk cycles (sampled per frame)
//   busy_o      : frame in progress (LEAD/DATA/TRAIL)
//   done_o      : one-cycle pulse in the final mclk cycle of TRAIL
//   dac_din     : serial data, MSB first
//   dac_sclk    : serial clock, idles high, falls mid-slot
//   dac_sync_n  : frame sync, low only during the 16 DATA slots
// -----------------------------------------------------------------------------
module soc_msp430_dac_spi #(
   parameter int DIV_W = 8
) (
   input  logic                 mclk,
   input  logic                 puc_rst,
   soc_msp430_dac_spi_if.slave  prod,
   input  logic [DIV_W-1:0]     clk_div_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 dac_din,
   output logic                 dac_sclk,
   output logic                 dac_sync_n
);

   // Wide enough for H = 2^DIV_W and for the slot counter up to 2H-1.
   localparam int CW = DIV_W + 2;

   typedef enum logic [1:0] {IDLE, LEAD, DATA, TRAIL} state_t;

   state_t          r_state, w_state_n;
   logic [CW-1:0]   r_cnt,   w_cnt_n;
   logic [CW-1:0]   r_h,     w_h_n;
   logic [3:0]      r_bit,   w_bit_n;
   logic [15:0]     r_shift, w_shift_n;
   logic            r_pend_full, w_pend_full_n;
   logic [15:0]     r_pend;
   logic            r_rdy, r_busy, r_done, r_din, r_sclk, r_sync_n;

   logic [CW-1:0]   w_last, w_last_n, w_h_new;
   logic            w_slot_end, w_accept, w_load, w_load_pred;

   assign w_last     = {r_h[CW-2:0], 1'b0} - CW'(1);
   assign w_slot_end = (r_cnt == w_last);
   assign w_accept   = prod.dac_vld_i & r_rdy;
   assign w_load     = r_pend_full &
                       ((r_state == IDLE) | ((r_state == TRAIL) & w_slot_end));
   assign w_h_new    = CW'(clk_div_i) + CW'(1);

   // Next-state / datapath
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_h_n     = r_h;
      w_bit_n   = r_bit;
      w_shift_n = r_shift;

      if (r_state != IDLE)
         w_cnt_n = w_slot_end ? '0 : r_cnt + CW'(1);

      case (r_state)
         LEAD: if (w_slot_end) begin
            w_state_n = DATA;
            w_bit_n   = 4'd15;
         end
         DATA: if (w_slot_end) begin
            if (r_bit == 4'd0) begin
               w_state_n = TRAIL;
            end else begin
               w_bit_n   = r_bit - 4'd1;
               w_shift_n = {r_shift[14:0], 1'b0};
            end
         end
         TRAIL: if (w_slot_end) w_state_n = IDLE;
         default: ;
      endcase

      // Loading a new frame overrides the plain TRAIL->IDLE exit.
      if (w_load) begin
         w_state_n = LEAD;
         w_cnt_n   = '0;
         w_h_n     = w_h_new;
         w_shift_n = r_pend;
      end
   end

   assign w_pend_full_n = w_accept | (r_pend_full & ~w_load);
   assign w_last_n      = {w_h_n[CW-2:0], 1'b0} - CW'(1);
   // The slot is guaranteed to be freed on the next edge in these cases, so
   // a word offered then is taken on that same (freeing) edge.
   assign w_load_pred   = (w_state_n == IDLE) |
                          ((w_state_n == TRAIL) & (w_cnt_n == w_last_n));

   always_ff @(posedge mclk or posedge puc_rst) begin
      if (puc_rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_h         <= CW'(1);
         r_bit       <= '0;
         r_shift     <= '0;
         r_pend_full <= 1'b0;
         r_pend      <= '0;
         r_rdy       <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_din       <= 1'b0;
         r_sclk      <= 1'b1;
         r_sync_n    <= 1'b1;
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_h         <= w_h_n;
         r_bit       <= w_bit_n;
         r_shift     <= w_shift_n;
         r_pend_full <= w_pend_full_n;
         if (w_accept) r_pend <= {prod.dac_cfg_i, prod.dac_val_i};
         r_rdy       <= ~w_pend_full_n | w_load_pred;
         // Pins are registered from next-state so they never glitch.
         r_busy      <= (w_state_n != IDLE);
         r_done      <= (w_state_n == TRAIL) & (w_cnt_n == w_last_n);
         r_sclk      <= (w_state_n == IDLE) | (w_cnt_n < w_h_n);
         r_sync_n    <= (w_state_n != DATA);
         r_din       <= (w_state_n == DATA) & w_shift_n[15];
      end
   end

   assign prod.dac_rdy_o = r_rdy;
   assign busy_o         = r_busy;
   assign done_o         = r_done;
   assign dac_din        = r_din;
   assign dac_sclk       = r_sclk;
   assign dac_sync_n     = r_sync_n;

endmodule

// File: tb/tb_soc_msp430_dac_spi.sv
module tb_soc_msp430_dac_spi;
   logic       mclk = 1'b0;
   logic       puc_rst = 1'b1;
   logic [7:0] clk_div = 8'd0;
   logic       busy, done, din, sclk, sync_n;

   soc_msp430_dac_spi_if pif();

   soc_msp430_dac_spi #(.DIV_W(8)) dut (
      .mclk(mclk), .puc_rst(puc_rst), .prod(pif), .clk_div_i(clk_div),
      .busy_o(busy), .done_o(done), .dac_din(din), .dac_sclk(sclk),
      .dac_sync_n(sync_n));

   always #5 mclk = ~mclk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_to(string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out", nm);
   endtask

   // Scoreboard: expected 16-bit frames in acceptance order.
   logic [15:0] exp_q[$];

   // Board-level DAC model: shift din on sclk falls while sync_n low; the
   // first fall with sync_n high after exactly 16 bits latches [11:0].
   logic [15:0] dac_sr = '0;
   int          dac_cnt = 0;
   logic [11:0] dac_vout = '0;
   int          n_latched = 0;
   logic [15:0] dac_e;

   always @(negedge sclk) begin
      if (sync_n === 1'b0) begin
         dac_sr = {dac_sr[14:0], din};
         dac_cnt++;
      end else begin
         if (dac_cnt == 16) begin
            dac_vout = dac_sr[11:0];
            n_latched++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_frame: got 0x%0h expected none", dac_sr);
            end else begin
               dac_e = exp_q.pop_front();
               chk("frame_bits", {16'h0, dac_sr}, {16'h0, dac_e});
            end
         end
         dac_cnt = 0;
      end
   end

   // Timing monitor: frame length = 36H and every sclk low phase = H, where H
   // is clk_div+1 as it stood on the edge that began the frame.
   logic       prev_busy = 1'b0, prev_done = 1'b0;
   logic [7:0] prev_div = 8'd0;
   int flen = 0, fh = 1, lowrun = 0, n_done = 0;

   always @(negedge mclk) begin
      if (puc_rst) begin
         prev_busy = 1'b0;
         prev_done = 1'b0;
         flen      = 0;
         lowrun    = 0;
      end else begin
         if (busy && !sclk) lowrun++;
         else if (lowrun != 0) begin
            chk("sclk_low_len", lowrun, fh);
            lowrun = 0;
         end
         if (busy && (!prev_busy || prev_done)) begin
            fh   = int'(prev_div) + 1;
            flen = 0;
         end
         if (busy) flen++;
         if (done) begin
            n_done++;
            chk("frame_len", flen, 36 * fh);
            chk("done_single_cycle", prev_done, 1'b0);
         end
         prev_busy = busy;
         prev_done = done;
      end
      prev_div = clk_div;
   end

   // Offer a word, hold it until taken; push expectation on acceptance.
   task automatic send(input logic [11:0] v, input logic [3:0] c);
      int i;
      @(negedge mclk);
      pif.dac_val_i = v;
      pif.dac_cfg_i = c;
      pif.dac_vld_i = 1'b1;
      for (i = 0; i < 20000 && !pif.dac_rdy_o; i++) @(negedge mclk);
      if (!pif.dac_rdy_o) fail_to("send");
      else exp_q.push_back({c, v});
      @(posedge mclk);
      #1 pif.dac_vld_i = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      repeat (2) @(negedge mclk);
      for (i = 0; i < 20000 && (busy || exp_q.size() != 0); i++) @(negedge mclk);
      if (busy || exp_q.size() != 0) fail_to("wait_idle");
   endtask

   task automatic set_div(input logic [7:0] d);
      @(posedge mclk);
      #1 clk_div = d;
   endtask

   logic [11:0] vout_before;
   int          nd0;

   initial begin
      pif.dac_vld_i = 1'b0;
      pif.dac_val_i = '0;
      pif.dac_cfg_i = '0;
      repeat (3) @(posedge mclk);
      #1;
      chk("rst_sclk", sclk, 1'b1);
      chk("rst_sync_n", sync_n, 1'b1);
      chk("rst_din", din, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_rdy", pif.dac_rdy_o, 1'b1);
      puc_rst = 1'b0;

      // 1: single frame, H=1
      nd0 = n_done;
      fork
         send(12'hA5C, 4'h3);
         begin
            int lows = 0;
            repeat (45) begin
               @(negedge mclk);
               if (!pif.dac_rdy_o) lows++;
            end
            chk("t1_rdy_low_cycles", lows, 0);
         end
      join
      wait_idle();
      chk("t1_vout", dac_vout, 12'hA5C);
      chk("t1_done_count", n_done - nd0, 1);

      // 2: back-to-back, third word queued behind the second
      fork
         begin
            send(12'h123, 4'h0);
            send(12'hFED, 4'h0);
            @(negedge mclk);
            chk("t2_rdy_drop", pif.dac_rdy_o, 1'b0);
            send(12'($urandom), 4'($urandom));
         end
         begin
            int i, run;
            for (i = 0; i < 200 && !busy; i++) @(negedge mclk);
            run = 0;
            while (busy && run < 400) begin
               run++;
               @(negedge mclk);
            end
            chk("t2_contiguous_busy", run, 108);
         end
      join
      wait_idle();

      // 3: divider 3, changed to 0 mid-frame
      set_div(8'd3);
      fork
         send(12'($urandom), 4'($urandom));
         begin
            int i;
            for (i = 0; i < 200 && !busy; i++) @(negedge mclk);
            repeat (20) @(posedge mclk);
            #1 clk_div = 8'd0;
         end
      join
      wait_idle();

      // 4: reset mid-DATA (bit 7) with a word pending
      set_div(8'd1);
      vout_before = dac_vout;
      nd0 = n_done;
      send(12'h5A5, 4'h1);
      send(12'h3C3, 4'h2);
      repeat (38) @(posedge mclk);
      #2 puc_rst = 1'b1;
      #1;
      chk("t4_sclk", sclk, 1'b1);
      chk("t4_sync_n", sync_n, 1'b1);
      chk("t4_din", din, 1'b0);
      chk("t4_busy", busy, 1'b0);
      chk("t4_rdy", pif.dac_rdy_o, 1'b1);
      chk("t4_done", done, 1'b0);
      exp_q.delete();
      repeat (3) @(posedge mclk);
      #1 puc_rst = 1'b0;
      chk("t4_vout_held", dac_vout, vout_before);
      chk("t4_no_done", n_done - nd0, 0);
      send(12'h0FF, 4'h0);
      wait_idle();
      chk("t4_vout_next", dac_vout, 12'h0FF);

      // 5: word offered in the done cycle while the slot is full
      set_div(8'd0);
      send(12'h111, 4'h4);
      send(12'h222, 4'h5);
      begin
         int i;
         for (i = 0; i < 200 && !done; i++) @(negedge mclk);
         if (!done) fail_to("t5_done");
         pif.dac_val_i = 12'h333;
         pif.dac_cfg_i = 4'h6;
         pif.dac_vld_i = 1'b1;
         chk("t5_rdy_in_done_cycle", pif.dac_rdy_o, 1'b1);
         if (pif.dac_rdy_o) exp_q.push_back(16'h6333);
         @(posedge mclk);
         #1 pif.dac_vld_i = 1'b0;
      end
      wait_idle();
      chk("t5_vout", dac_vout, 12'h333);

      // 6: extremes
      send(12'h000, 4'($urandom));
      send(12'hFFF, 4'($urandom));
      wait_idle();
      chk("t6_vout", dac_vout, 12'hFFF);

      // Randomised traffic with occasional divider changes
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(0, 2) == 0) set_div(8'($urandom_range(0, 3)));
         send(12'($urandom), 4'($urandom));
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();

      // Maximum divider
      set_div(8'hFF);
      send(12'h9C6, 4'hA);
      wait_idle();
      chk("max_div_vout", dac_vout, 12'h9C6);

      chk("queue_empty", exp_q.size(), 0);
      chk("done_vs_latched", n_done, n_latched);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
